// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl_if
//  Description : Request/response bundle between two requesters and the
//                ALU issue controller.
//                req_valid/req_ready  - per-requester request handshake
//                req_instr/ra/rb      - packed {req1, req0} payloads
//                resp_valid/ready     - per-requester response handshake
//                resp_result/branch/illegal - response payload
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [63:0]  req_instr;
    logic [127:0] req_ra;
    logic [127:0] req_rb;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [63:0]  resp_result;
    logic         resp_branch;
    logic         resp_illegal;

    // Requester side
    modport master (
        output req_valid, req_instr, req_ra, req_rb, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_branch, resp_illegal
    );

    // Controller side
    modport slave (
        input  req_valid, req_instr, req_ra, req_rb, resp_ready,
        output req_ready, resp_valid, resp_result, resp_branch, resp_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Two-requester round-robin front end for a combinational ALU.
//                Accepts one instruction at a time, decodes it into ALU
//                fields, holds the ALU inputs for ALU_LAT cycles, captures
//                the result and returns it to the originating requester.
//                Unsupported opcodes bypass the ALU and return illegal.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                bus (slave)      - request/response handshake bundle
//                alu_*            - decoded fields and operands to the ALU
//                alu_result/branch- combinational ALU outputs
//                busy             - high whenever not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_issue_ctrl_if.slave    bus,
    output logic [5:0]         alu_opcode,
    output logic [9:0]         alu_xo,
    output logic [8:0]         alu_xoxo,
    output logic               alu_aa,
    output logic [15:0]        alu_si,
    output logic [13:0]        alu_ds,
    output logic [63:0]        alu_rs,
    output logic [63:0]        alu_rt,
    input  logic [63:0]        alu_result,
    input  logic               alu_branch,
    output logic               busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    localparam logic [3:0] c_LAT_M1 = 4'(ALU_LAT - 1);

    logic [1:0]  r_state;
    logic        r_last;      // requester granted most recently
    logic        r_owner;     // requester that owns the in-flight operation
    logic [31:0] r_instr;
    logic [63:0] r_ra;
    logic [63:0] r_rb;
    logic [3:0]  r_cnt;
    logic [63:0] r_result;
    logic        r_branch;
    logic        r_illegal;

    logic        w_gid;
    logic        w_accept;
    logic        w_take;
    logic [31:0] w_sel_instr;
    logic [63:0] w_sel_ra;
    logic [63:0] w_sel_rb;
    logic        w_sel_ok;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            6'd14, 6'd15, 6'd18, 6'd19, 6'd24, 6'd26, 6'd28, 6'd31, 6'd32,
            6'd34, 6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44, 6'd58, 6'd62:
                op_supported = 1'b1;
            default:
                op_supported = 1'b0;
        endcase
    endfunction

    // Round-robin: on contention the requester not granted last wins;
    // a lone valid requester always wins.
    always_comb begin
        if (&bus.req_valid) begin
            w_gid = ~r_last;
        end else begin
            w_gid = bus.req_valid[1];
        end
    end

    assign w_accept      = (r_state == c_IDLE) && !rst && (|bus.req_valid);
    assign bus.req_ready = w_accept ? (w_gid ? 2'b10 : 2'b01) : 2'b00;

    assign w_sel_instr = w_gid ? bus.req_instr[63:32] : bus.req_instr[31:0];
    assign w_sel_ra    = w_gid ? bus.req_ra[127:64]   : bus.req_ra[63:0];
    assign w_sel_rb    = w_gid ? bus.req_rb[127:64]   : bus.req_rb[63:0];
    assign w_sel_ok    = op_supported(w_sel_instr[31:26]);

    // Only the owner's resp_ready can retire the response.
    assign w_take = (r_state == c_RESP) && bus.resp_ready[r_owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_last    <= 1'b1;     // requester 0 wins the first contention
            r_owner   <= 1'b0;
            r_instr   <= 32'd0;
            r_ra      <= 64'd0;
            r_rb      <= 64'd0;
            r_cnt     <= 4'd0;
            r_result  <= 64'd0;
            r_branch  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_instr <= w_sel_instr;
                        r_ra    <= w_sel_ra;
                        r_rb    <= w_sel_rb;
                        r_owner <= w_gid;
                        r_last  <= w_gid;
                        if (w_sel_ok) begin
                            r_state <= c_ISSUE;
                            r_cnt   <= c_LAT_M1;
                        end else begin
                            // Unsupported opcode skips the ALU entirely.
                            r_state   <= c_RESP;
                            r_result  <= 64'd0;
                            r_branch  <= 1'b0;
                            r_illegal <= 1'b1;
                        end
                    end
                end
                c_ISSUE: begin
                    if (r_cnt == 4'd0) begin
                        r_result  <= alu_result;
                        r_branch  <= alu_branch;
                        r_illegal <= 1'b0;
                        r_state   <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    if (w_take) begin
                        r_state   <= c_IDLE;
                        r_result  <= 64'd0;
                        r_branch  <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ALU fields are presented only while issuing; zero otherwise.
    always_comb begin
        alu_opcode = 6'd0;
        alu_xo     = 10'd0;
        alu_xoxo   = 9'd0;
        alu_aa     = 1'b0;
        alu_si     = 16'd0;
        alu_ds     = 14'd0;
        alu_rs     = 64'd0;
        alu_rt     = 64'd0;
        if (r_state == c_ISSUE) begin
            alu_opcode = r_instr[31:26];
            alu_aa     = r_instr[1];
            alu_rs     = r_ra;
            alu_rt     = r_rb;
            if (r_instr[31:26] == 6'd31) begin
                // Two extended-opcode forms use the 9-bit field.
                if ((r_instr[9:1] == 9'd266) || (r_instr[9:1] == 9'd40)) begin
                    alu_xoxo = r_instr[9:1];
                end else begin
                    alu_xo = r_instr[10:1];
                end
            end
            if ((r_instr[31:26] == 6'd58) || (r_instr[31:26] == 6'd62)) begin
                alu_ds = r_instr[15:2];
            end else begin
                alu_si = r_instr[15:0];
            end
        end
    end

    logic w_unused_bits;
    assign w_unused_bits = ^r_instr[25:16];

    assign bus.resp_valid   = (r_state == c_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_result  = r_result;
    assign bus.resp_branch  = r_branch;
    assign bus.resp_illegal = r_illegal;
    assign busy             = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Transaction-level bench for alu_issue_ctrl. A stub ALU
//                computes results from the decoded fields; a reference model
//                predicts grants, decode, latency and responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  alu_opcode;
    logic [9:0]  alu_xo;
    logic [8:0]  alu_xoxo;
    logic        alu_aa;
    logic [15:0] alu_si;
    logic [13:0] alu_ds;
    logic [63:0] alu_rs;
    logic [63:0] alu_rt;
    logic [63:0] alu_result;
    logic        alu_branch;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int m_last = 1;   // model: requester granted most recently

    int sup_ops [18] = '{14, 15, 18, 19, 24, 26, 28, 31, 32,
                         34, 36, 37, 38, 40, 42, 44, 58, 62};

    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_xo     (alu_xo),
        .alu_xoxo   (alu_xoxo),
        .alu_aa     (alu_aa),
        .alu_si     (alu_si),
        .alu_ds     (alu_ds),
        .alu_rs     (alu_rs),
        .alu_rt     (alu_rt),
        .alu_result (alu_result),
        .alu_branch (alu_branch),
        .busy       (busy)
    );

    // Field pack: {op[6], xo[10], xoxo[9], aa[1], si[16], ds[14]} = 56 bits
    function automatic logic [55:0] decode_fields(input logic [31:0] ins);
        logic [5:0]  op;
        logic [9:0]  xo;
        logic [8:0]  xoxo;
        logic [15:0] si;
        logic [13:0] ds;
        op   = ins[31:26];
        xo   = 10'd0;
        xoxo = 9'd0;
        si   = ins[15:0];
        ds   = 14'd0;
        if (op == 6'd31) begin
            if (ins[9:1] == 9'd266 || ins[9:1] == 9'd40) xoxo = ins[9:1];
            else xo = ins[10:1];
        end
        if (op == 6'd58 || op == 6'd62) begin
            si = 16'd0;
            ds = ins[15:2];
        end
        return {op, xo, xoxo, ins[1], si, ds};
    endfunction

    function automatic logic is_supported(input logic [5:0] op);
        for (int i = 0; i < 18; i++) begin
            if (int'(op) == sup_ops[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Stub ALU: returns {branch, result[63:0]}
    function automatic logic [64:0] alu_stub(input logic [55:0] f,
                                             input logic [63:0] rs,
                                             input logic [63:0] rt);
        logic [5:0]  op;
        logic [63:0] res;
        logic        br;
        op  = f[55:50];
        br  = 1'b0;
        if (op == 6'd18 || op == 6'd19) begin
            res = 64'd0;
            br  = (rs == rt) && f[30];
        end else if (op == 6'd31) begin
            res = rs + rt + 64'(f[49:40]) + ((f[39:31] == 9'd40) ? 64'd1000 : 64'd0);
        end else begin
            res = rs + rt + {{48{f[29]}}, f[29:14]} + (64'(f[13:0]) << 2);
        end
        return {br, res};
    endfunction

    always_comb begin
        {alu_branch, alu_result} = alu_stub(
            {alu_opcode, alu_xo, alu_xoxo, alu_aa, alu_si, alu_ds}, alu_rs, alu_rt);
    end

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 9) < 7) w[31:26] = 6'(sup_ops[$urandom_range(0, 17)]);
        else w[31:26] = 6'($urandom_range(0, 63));
        if (w[31:26] == 6'd31 && $urandom_range(0, 2) != 0)
            w[9:1] = ($urandom_range(0, 1) == 1) ? 9'd266 : 9'd40;
        return w;
    endfunction

    function automatic logic [55:0] dut_fields();
        return {alu_opcode, alu_xo, alu_xoxo, alu_aa, alu_si, alu_ds};
    endfunction

    // Starts between a negedge and the following posedge with the DUT idle.
    task automatic run_txn(input logic [1:0] vld, input logic [31:0] i0, input logic [31:0] i1,
                           input logic [63:0] a0, input logic [63:0] b0,
                           input logic [63:0] a1, input logic [63:0] b1, input int stall);
        int          g;
        logic [1:0]  oh;
        logic [31:0] ins;
        logic [63:0] ra, rb;
        logic [55:0] f;
        logic        sup;
        logic [64:0] er;
        bus.req_valid  = vld;
        bus.req_instr  = {i1, i0};
        bus.req_ra     = {a1, a0};
        bus.req_rb     = {b1, b0};
        bus.resp_ready = 2'b00;
        #1;
        if (vld == 2'b11) g = (m_last == 1) ? 0 : 1;
        else              g = vld[1] ? 1 : 0;
        oh = (g == 1) ? 2'b10 : 2'b01;
        check_val("req_ready_grant", 128'(bus.req_ready), 128'(oh));
        check_val("busy_idle", 128'(busy), 128'(0));
        @(posedge clk);
        m_last = g;
        ins = (g == 1) ? i1 : i0;
        ra  = (g == 1) ? a1 : a0;
        rb  = (g == 1) ? b1 : b0;
        f   = decode_fields(ins);
        sup = is_supported(ins[31:26]);
        er  = sup ? alu_stub(f, ra, rb) : 65'd0;
        @(negedge clk);
        if (sup) begin
            for (int k = 0; k < LAT; k++) begin
                #1;
                check_val("issue_busy", 128'(busy), 128'(1));
                check_val("issue_resp_valid", 128'(bus.resp_valid), 128'(0));
                check_val("issue_req_ready", 128'(bus.req_ready), 128'(0));
                check_val("issue_fields", 128'(dut_fields()), 128'(f));
                check_val("issue_rs_rt", {alu_rs, alu_rt}, {ra, rb});
                @(negedge clk);
            end
        end
        for (int s = 0; s <= stall; s++) begin
            #1;
            check_val("resp_valid", 128'(bus.resp_valid), 128'(oh));
            check_val("resp_result", 128'(bus.resp_result), 128'(er[63:0]));
            check_val("resp_branch", 128'(bus.resp_branch), 128'(er[64]));
            check_val("resp_illegal", 128'(bus.resp_illegal), 128'(!sup));
            check_val("resp_busy", 128'(busy), 128'(1));
            check_val("resp_req_ready", 128'(bus.req_ready), 128'(0));
            check_val("resp_fields_zero", 128'(dut_fields()), 128'(0));
            if (s < stall) bus.resp_ready = ~oh & 2'($urandom_range(0, 3));
            else           bus.resp_ready = oh | 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        #1;
        check_val("post_busy", 128'(busy), 128'(0));
        check_val("post_resp_valid", 128'(bus.resp_valid), 128'(0));
    endtask

    task automatic run_random();
        logic [1:0]  vld;
        logic [63:0] a0, b0, a1, b1;
        vld = 2'($urandom_range(1, 3));
        a0  = {$urandom(), $urandom()};
        a1  = {$urandom(), $urandom()};
        b0  = ($urandom_range(0, 3) == 0) ? a0 : {$urandom(), $urandom()};
        b1  = ($urandom_range(0, 3) == 0) ? a1 : {$urandom(), $urandom()};
        run_txn(vld, rand_instr(), rand_instr(), a0, b0, a1, b1, int'($urandom_range(0, 3)));
    endtask

    task automatic reset_mid_issue();
        bus.req_valid  = 2'b01;
        bus.req_instr  = {32'h0, 32'h7C000214};
        bus.req_ra     = {64'd0, 64'd3};
        bus.req_rb     = {64'd0, 64'd5};
        bus.resp_ready = 2'b11;
        #1;
        check_val("rst_txn_grant", 128'(bus.req_ready), 128'(2'b01));
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("rst_pre_busy", 128'(busy), 128'(1));
        rst = 1'b1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_resp", {bus.resp_valid, bus.resp_result, bus.resp_branch, bus.resp_illegal},
                  128'(0));
        check_val("rst_fields", 128'(dut_fields()), 128'(0));
        check_val("rst_rs_rt", {alu_rs, alu_rt}, 128'(0));
        rst    = 1'b0;
        m_last = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check_val("rst_no_resp", 128'(bus.resp_valid), 128'(0));
            check_val("rst_idle", 128'(busy), 128'(0));
        end
        bus.resp_ready = 2'b00;
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_instr  = 64'd0;
        bus.req_ra     = 128'd0;
        bus.req_rb     = 128'd0;
        bus.resp_ready = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_busy", 128'(busy), 128'(0));
        check_val("reset_handshake", 128'({bus.req_ready, bus.resp_valid}), 128'(0));
        check_val("reset_resp", {bus.resp_result, bus.resp_branch, bus.resp_illegal}, 128'(0));
        check_val("reset_fields", 128'(dut_fields()), 128'(0));
        rst    = 1'b0;
        m_last = 1;

        // Contention after reset: req0 (ADDI) first, then req1 (ADD), then req0
        run_txn(2'b11, 32'h380000FA, 32'h7C000214, 64'd0, 64'd8, 64'd3, 64'd5, 0);
        run_txn(2'b11, 32'h380000FA, 32'h7C000214, 64'd0, 64'd8, 64'd3, 64'd5, 0);
        run_txn(2'b11, 32'h380000FA, 32'h7C000214, 64'd0, 64'd8, 64'd3, 64'd5, 1);
        // ADD on req0
        run_txn(2'b01, 32'h7C000214, 32'h0, 64'd3, 64'd5, 64'd0, 64'd0, 0);
        // Branch-class opcode on req1
        run_txn(2'b10, 32'h0, 32'h4C000002, 64'd0, 64'd0, 64'd7, 64'd7, 0);
        // Unsupported opcode
        run_txn(2'b01, 32'h0, 32'h0, 64'd9, 64'd9, 64'd0, 64'd0, 0);
        // Response stalled three cycles
        run_txn(2'b01, 32'h7C000214, 32'h0, 64'd3, 64'd5, 64'd0, 64'd0, 3);

        repeat (150) run_random();
        reset_mid_issue();
        run_txn(2'b01, 32'h7C000214, 32'h0, 64'd10, 64'd20, 64'd0, 64'd0, 0);
        repeat (30) run_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter ALU_LAT, default 1, number of cycles the ALU inputs are held before the result is sampled (legal 1..15).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  out  2  per-requester accept strobe; a request is taken on any cycle where req_valid[i] && req_ready[i].
REQ-006 req_instr  in  64  two 32-bit instruction words, {req1, req0}.
REQ-007 req_ra  in  128  two 64-bit first operands, {req1, req0}.
REQ-008 req_rb  in  128  two 64-bit second operands, {req1, req0}.
REQ-009 resp_valid  out  2  response valid, one-hot to the originating requester.
REQ-010 resp_ready  in  2  per-requester response accept.
REQ-011 resp_result  out  64  captured ALU result.
REQ-012 resp_branch  out  1  captured ALU branch flag.
REQ-013 resp_illegal  out  1  unsupported opcode flag.
REQ-014 alu_opcode/alu_xo/alu_xoxo/alu_aa/alu_si/alu_ds  out  6/10/9/1/16/14  decoded fields to the ALU.
REQ-015 alu_rs, alu_rt  out  64 each  operands to the ALU (alu_rs = ra, alu_rt = rb).
REQ-016 alu_result  in  64; alu_branch  in  1  combinational ALU outputs.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, RESP; IDLE -> ISSUE on accept of a supported opcode; IDLE -> RESP on accept of an unsupported opcode; ISSUE -> RESP after ALU_LAT cycles; RESP -> IDLE when resp_ready of the owner is high.
REQ-019 req_ready is nonzero only in IDLE, at most one bit set, and only for a requester with req_valid high.
REQ-020 Arbitration round-robin: if both valid, grant the requester not granted last; a single valid requester is always granted; pointer updates only on accept.
REQ-021 On accept, instr, ra, rb and owner id are registered; inputs are not sampled again until the next accept.
REQ-022 Decode: opcode = instr[31:26]; si = instr[15:0]; ds = instr[15:2]; aa = instr[1].
REQ-023 opcode 31 with instr[9:1] equal to 266 or 40: alu_xoxo = instr[9:1], alu_xo = 0; other opcode 31: alu_xoxo = 0, alu_xo = instr[10:1]; opcode not 31: both 0.
REQ-024 opcode 58 or 62: alu_si = 0, alu_ds = ds; all other opcodes: alu_si = si, alu_ds = 0.
REQ-025 Supported opcodes: 14,15,18,19,24,26,28,31,32,34,36,37,38,40,42,44,58,62; any other is unsupported.
REQ-026 All alu_* outputs are driven from registered decode during ISSUE and are 0 in IDLE and RESP.
REQ-027 ISSUE lasts exactly ALU_LAT cycles (4-bit down-counter); alu_result and alu_branch are captured on the last ISSUE cycle.
REQ-028 Latency accept-edge to resp_valid = ALU_LAT + 1 cycles for supported, 1 cycle for unsupported.
REQ-029 Unsupported: no ISSUE, resp_result = 0, resp_branch = 0, resp_illegal = 1.
REQ-030 resp_result, resp_branch, resp_illegal and resp_valid are held stable throughout RESP until accepted; resp_ready of the non-owner is ignored.
REQ-031 No accept in the cycle a response is consumed; next accept is earliest the following cycle (throughput one per ALU_LAT + 2 cycles).
REQ-032 req_valid deasserting while not granted drops that request without side effects.

Reset
REQ-033 rst high at a clock edge forces IDLE; req_ready, resp_valid, resp_result, resp_branch, resp_illegal, busy and all alu_* outputs are 0; round-robin pointer set so requester 0 wins first.
REQ-034 Reset during ISSUE or RESP discards the in-flight operation; no response is ever issued for it.

Verification
REQ-035 req0 instr 0x7C000214 (ADD), ra=3, rb=5, ALU_LAT=1 -> resp_valid=01 two cycles after accept, resp_result=8, resp_branch=0, resp_illegal=0.
REQ-036 req1 instr 0x4C000002 (opcode 19, aa=1), ra=7, rb=7 -> resp_valid=10, resp_branch=1, resp_result=0; alu_xo=alu_xoxo=0 during ISSUE.
REQ-037 Both valid after reset: req0 instr 0x380000FA (ADDI, si=250) rb=8, req1 ADD 3+5 -> req0 served first (result 258), then req1 (result 8); pointer alternates on repeated contention.
REQ-038 req0 instr 0x00000000 (opcode 0) -> resp_valid=01 one cycle after accept, resp_illegal=1, resp_result=0, no ISSUE cycle, alu_opcode stays 0.
REQ-039 resp_ready held low 3 cycles in RESP -> resp_valid, resp_result stable, req_ready=00, busy=1; accepted on 4th cycle, then IDLE.
REQ-040 rst asserted mid-ISSUE with ALU_LAT=4 -> next cycle all outputs 0, busy=0, no resp_valid for the aborted request; fresh request then completes normally.
